// File: rtl/logic_unit_pipe.sv
// WIDTH-bit bitwise logic unit with valid/ready handshake, accumulator feedback,
// one-deep registered output stage, zero/parity flags and a saturating op counter.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             out_valid_reg;
  logic             zero_reg;
  logic             parity_reg;
  logic [CNT_W-1:0] count_reg;

  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] result_next;
  logic             accept;

  // The output register frees up in the same cycle it is consumed, so a
  // consumer holding out_ready high sustains one operation per cycle.
  assign in_ready  = !out_valid_reg || out_ready;
  assign accept    = in_valid && in_ready;
  assign operand_a = acc_en ? acc_reg : a;

  always_comb begin
    result_next = '0;
    case (op)
      3'b000:  result_next = operand_a & b;
      3'b001:  result_next = ~(operand_a & b);
      3'b010:  result_next = operand_a | b;
      3'b011:  result_next = ~(operand_a | b);
      3'b100:  result_next = operand_a ^ b;
      3'b101:  result_next = ~(operand_a ^ b);
      3'b110:  result_next = ~operand_a;
      default: result_next = operand_a;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_reg    <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      zero_reg      <= 1'b1;
      parity_reg    <= 1'b0;
      count_reg     <= '0;
    end else if (accept) begin
      result_reg    <= result_next;
      acc_reg       <= result_next;
      out_valid_reg <= 1'b1;
      zero_reg      <= (result_next == '0);
      parity_reg    <= ^result_next;
      if (count_reg != CNT_MAX) begin
        count_reg <= count_reg + 1'b1;
      end
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign result    = result_reg;
  assign out_valid = out_valid_reg;
  assign zero      = zero_reg;
  assign parity    = parity_reg;
  assign op_count  = count_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: a 16-bit-counter instance and a 2-bit-counter
// instance share all inputs; expected results are queued at drive time.
`timescale 1ns/1ps
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  op;
  logic        acc_en;
  logic        out_ready;
  logic        in_ready, in_ready2;
  logic        out_valid, out_valid2;
  logic [7:0]  result, result2;
  logic        zero, zero2, parity, parity2;
  logic [15:0] op_count;
  logic [1:0]  op_count2;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic       m_valid;
  logic [7:0] m_acc;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .parity(parity),
    .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .out_valid(out_valid2),
    .out_ready(out_ready), .result(result2), .zero(zero2), .parity(parity2),
    .op_count(op_count2)
  );

  function automatic logic [7:0] model_f(input logic [2:0] f_op, input logic [7:0] x,
                                         input logic [7:0] y);
    case (f_op)
      3'd0:    return x & y;
      3'd1:    return ~(x & y);
      3'd2:    return x | y;
      3'd3:    return ~(x | y);
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  // Drives one cycle of stimulus, updates the reference model and queues the
  // expected result if the transfer is accepted; returns 1 ns after the edge.
  task automatic step(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [2:0] iop, input logic iacc, input logic ordy,
                      output logic accepted);
    logic [7:0] e;
    in_valid  = v;
    a         = ia;
    b         = ib;
    op        = iop;
    acc_en    = iacc;
    out_ready = ordy;
    accepted  = (v === 1'b1) && (!m_valid || ordy);
    if (accepted) begin
      e = model_f(iop, iacc ? m_acc : ia, ib);
      sb.push_back(e);
      m_acc   = e;
      m_valid = 1'b1;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    #2;
    reset     = 1'b0;
    sb.delete();
    m_valid = 1'b0;
    m_acc   = 8'h00;
  endtask

  task automatic test_reset();
    logic acc;
    in_valid = 1'b0; a = '0; b = '0; op = '0; acc_en = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (result !== 8'h00 || zero !== 1'b1 || parity !== 1'b0 || out_valid !== 1'b0 ||
        in_ready !== 1'b1 || op_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got result=%h zero=%b parity=%b out_valid=%b in_ready=%b count=%0d required 00 1 0 0 1 0",
               result, zero, parity, out_valid, in_ready, op_count);
    end
    do_reset();
    step(1'b0, 8'hxx, 8'hxx, 3'bxxx, 1'b0, 1'b1, acc);
    checks++;
    if (out_valid !== 1'b0 || result !== 8'h00 || op_count !== 16'd0) begin
      errors++;
      $display("FAIL x_idle: got out_valid=%b result=%h count=%0d required 0 00 0",
               out_valid, result, op_count);
    end
    $display("test_reset done");
  endtask

  task automatic test_ops();
    logic [7:0] table_exp [8] = '{8'h30, 8'hCF, 8'hFC, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'hF0};
    logic [7:0] e;
    logic acc;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'hF0, 8'h3C, 3'(i), 1'b0, 1'b1, acc);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || result !== table_exp[i] || result !== e ||
          zero !== (e == 8'h00) || parity !== ^e) begin
        errors++;
        $display("FAIL op_%0d: got valid=%b result=%h zero=%b parity=%b required 1 %h %b %b",
                 i, out_valid, result, zero, parity, table_exp[i], e == 8'h00, ^e);
      end
      $display("op=%0d a=F0 b=3C result=%h", i, result);
    end
    checks++;
    if (op_count !== 16'd8) begin
      errors++;
      $display("FAIL op_count_8: got %0d required 8", op_count);
    end
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, acc);
    checks++;
    if (out_valid !== 1'b0 || result !== 8'hF0) begin
      errors++;
      $display("FAIL drain: got valid=%b result=%h required 0 f0", out_valid, result);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e;
    logic [15:0] cnt_hold;
    logic acc;
    do_reset();
    step(1'b1, 8'hAA, 8'h0F, 3'd4, 1'b0, 1'b0, acc);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || result !== 8'hA5 || result !== e) begin
      errors++;
      $display("FAIL bp_first: got valid=%b result=%h required 1 a5", out_valid, result);
    end
    cnt_hold = op_count;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 3'(i), 1'b0, 1'b0, acc);
      checks++;
      if (in_ready !== 1'b0 || result !== 8'hA5 || parity !== 1'b0 || zero !== 1'b0 ||
          op_count !== cnt_hold || out_valid !== 1'b1 || acc) begin
        errors++;
        $display("FAIL bp_stall_%0d: got in_ready=%b result=%h parity=%b count=%0d required 0 a5 0 %0d",
                 i, in_ready, result, parity, op_count, cnt_hold);
      end
      $display("stall cycle %0d result=%h in_ready=%b", i, result, in_ready);
    end
    step(1'b1, 8'h12, 8'h34, 3'd0, 1'b0, 1'b1, acc);
    e = sb.pop_front();
    checks++;
    if (result !== e || result !== 8'h10 || out_valid !== 1'b1 || op_count !== cnt_hold + 16'd1) begin
      errors++;
      $display("FAIL bp_release: got result=%h count=%0d required 10 %0d",
               result, op_count, cnt_hold + 16'd1);
    end
  endtask

  task automatic test_accumulate();
    logic [7:0] bs   [4] = '{8'h01, 8'h02, 8'h04, 8'h00};
    logic [2:0] ops  [4] = '{3'd2, 3'd2, 3'd2, 3'd6};
    logic [7:0] want [4] = '{8'h01, 8'h03, 8'h07, 8'hF8};
    logic [7:0] e;
    logic acc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'($urandom), bs[i], ops[i], 1'b1, 1'b1, acc);
      e = sb.pop_front();
      checks++;
      if (result !== want[i] || result !== e) begin
        errors++;
        $display("FAIL acc_%0d: got %h required %h", i, result, want[i]);
      end
      $display("acc op=%0d b=%h result=%h", ops[i], bs[i], result);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic acc;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 8'(i), 8'($urandom), 3'd7, 1'b0, 1'b1, acc);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== 8'(i) || result !== e) begin
        errors++;
        $display("FAIL b2b_%0d: got valid=%b in_ready=%b result=%h required 1 1 %h",
                 i, out_valid, in_ready, result, 8'(i));
      end
      $display("b2b a=%0d result=%h", i, result);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [7:0] e;
    logic acc;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0, 1'b1, acc);
      e = sb.pop_front();
      checks++;
      if (op_count2 !== want[i] || op_count !== 16'(i + 1) || result2 !== e) begin
        errors++;
        $display("FAIL sat_%0d: got count2=%0d count=%0d result2=%h required %0d %0d %h",
                 i, op_count2, op_count, result2, want[i], i + 1, e);
      end
      $display("sat accept %0d count2=%0d", i, op_count2);
    end
  endtask

  task automatic test_reset_stall();
    logic [7:0] e;
    logic acc;
    do_reset();
    step(1'b1, 8'hFF, 8'h00, 3'd7, 1'b0, 1'b0, acc);
    e = sb.pop_front();
    step(1'b1, 8'h11, 8'h22, 3'd0, 1'b0, 1'b0, acc);
    checks++;
    if (result !== 8'hFF || result !== e || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup: got result=%h valid=%b required ff 1", result, out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 8'h00 || zero !== 1'b1 || op_count !== 16'd0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: got valid=%b result=%h zero=%b count=%0d in_ready=%b required 0 00 1 0 1",
               out_valid, result, zero, op_count, in_ready);
    end
    reset = 1'b0;
    sb.delete();
    m_valid = 1'b0;
    m_acc   = 8'h00;
    step(1'b1, 8'h55, 8'hAA, 3'd7, 1'b1, 1'b1, acc);
    e = sb.pop_front();
    checks++;
    if (result !== 8'h00 || result !== e || zero !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_acc: got result=%h zero=%b valid=%b required 00 1 1", result, zero, out_valid);
    end
    $display("reset mid-stall then acc pass result=%h", result);
  endtask

  initial begin
    m_valid = 1'b0;
    m_acc   = 8'h00;
    test_reset();
    test_ops();
    test_backpressure();
    test_accumulate();
    test_back_to_back();
    test_saturation();
    test_reset_stall();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d entries required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised successor to the team's single-bit OR/NOR selectable gate.
- WIDTH-bit bitwise logic unit with eight selectable operations and a valid/ready handshake on input and output.
- Accumulate mode feeds the last result back as operand A.
- Has a one-deep registered output stage, zero/parity flags and a saturating operation counter.
- Sits between a register-file/operand source and a result consumer in the datapath guides.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 16, width of the operation counter (>=1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/op present
- in_ready  out  1  unit can accept this cycle
- a  in  WIDTH  operand A (ignored when acc_en=1)
- b  in  WIDTH  operand B
- op  in  3  operation select
- acc_en  in  1  use accumulator as operand A
- out_valid  out  1  result register holds unconsumed result
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- parity  out  1  XOR-reduction of result
- op_count  out  CNT_W  number of accepted operations, saturating

Behaviour:
- Op encoding, all bitwise over WIDTH bits, with A = acc_en ? acc : a:
  - 000 AND
  - 001 NAND
  - 010 OR
  - 011 NOR
  - 100 XOR
  - 101 XNOR
  - 110 NOT A (b ignored)
  - 111 PASS A (b ignored)
- Reset (async, immediate, regardless of clk):
  - out_valid=0, result=0, zero=1, parity=0, op_count=0, acc=0.
  - in_ready is combinational, so it reads 1 during reset.
- in_ready = !out_valid | out_ready. Purely combinational, with no dependency on in_valid.
- Accept: in_valid & in_ready at a rising edge. On the same edge:
  - result <= F(op, A, b)
  - acc <= same value
  - out_valid <= 1
  - op_count increments
- Latency: exactly 1 cycle from accept edge to result/out_valid visible.
- Full throughput: a consumer holding out_ready=1 allows one accept per cycle.
- Output consumed (out_valid & out_ready) with no new accept: out_valid <= 0. result and acc hold their values.
- Simultaneous consume and accept: out_valid stays 1 and result takes the new value. No bubble, no loss.
- Stall (out_valid=1, out_ready=0):
  - in_ready=0
  - result, zero, parity and op_count hold stable
  - inputs are ignored even if in_valid=1
- zero and parity are registered with result (derived from the next-result value). They always match result, including after reset.
- acc updates only on accept, never on consume.
- acc_en=1 on the first op after reset uses acc=0.
- op_count saturates at 2^CNT_W-1 and never wraps. Only reset clears it.
- Reset asserted mid-stall or mid-transfer: the pending result is discarded. Outputs return to reset values immediately. The first accept after deassertion behaves as after power-up.
- X on op/a/b while in_valid=0 must not affect state.

Test Plan:
1. WIDTH=8. After reset, check result=0x00, zero=1, parity=0, out_valid=0, in_ready=1, op_count=0. Then accept a=0xF0, b=0x3C for each op 000..111 with out_ready=1. Required results one cycle later, in order: 0x30, 0xCF, 0xFC, 0x03, 0xCC, 0x33, 0x0F, 0xF0. op_count must be 8.
2. Backpressure:
   - Accept a=0xAA, b=0x0F with op=100; out_valid=1 and result=0xA5.
   - Hold out_ready=0 for 3 cycles with in_valid=1 and different operands. Required: in_ready=0, result=0xA5, parity=0, op_count unchanged.
   - Raise out_ready. Next data is accepted on that edge.
3. Accumulate: after reset, apply acc_en=1 with op=010 and b=0x01, 0x02, 0x04 on consecutive cycles, out_ready=1. Required results: 0x01, 0x03, 0x07. Then op=110 with acc_en=1 gives 0xF8.
4. Simultaneous consume+accept: hold in_valid=1 and out_ready=1 for 4 cycles with op=111 and a=1,2,3,4. Required: out_valid stays 1 and results 1,2,3,4 appear on consecutive cycles.
5. Saturation with CNT_W=2: accept 5 ops. Required: op_count sequence 1,2,3,3,3.
6. Reset mid-stall: hold result=0xFF with out_ready=0, then pulse reset between clock edges. Required: out_valid=0, result=0x00 and zero=1 immediately. Next acc_en=1, op=111 yields 0x00.
